condicionador_botoes: RTL

//  Input stage in front of circuito_jogo_base: conditions raw pushbuttons into clean, one-hot play inputs.

---
 rtl/condicionador_botoes.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/condicionador_botoes.sv
// Pushbutton conditioner: 2-FF sync, press/release debounce, one accepted button at a time.
// Define REJEITA_MULTIPLOS_EN to reject multi-button presses instead of resolving to the lowest index.
module condicionador_botoes #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_BOTOES-1:0]         botoes_raw,
  input  logic                        habilita,
  output logic [N_BOTOES-1:0]         botoes,
  output logic                        jogada_pulso,
  output logic [$clog2(N_BOTOES)-1:0] jogada_codigo,
  output logic                        multiplo,
  output logic [3:0]                  db_estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int COD_W = $clog2(N_BOTOES);
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    FILTRANDO   = 4'd1,
    PRESSIONADO = 4'd2,
    SOLTANDO    = 4'd3,
    REJEITADO   = 4'd4
  } estado_t;

  estado_t             r_estado, w_prox_estado;
  logic [N_BOTOES-1:0] r_sinc1, r_sinc;
  logic [N_BOTOES-1:0] r_cand, w_prox_cand;
  logic [N_BOTOES-1:0] r_botoes, w_prox_botoes;
  logic [N_BOTOES-1:0] w_resolvido;
  logic [CNT_W-1:0]    r_cnt, w_prox_cnt, w_cnt_inc;
  logic [COD_W-1:0]    r_codigo, w_prox_codigo, w_indice;
  logic                r_pulso, w_prox_pulso;
  logic                r_multiplo, w_prox_multiplo;
`ifdef REJEITA_MULTIPLOS_EN
  logic                w_multiplos;
  assign w_multiplos = (r_cand & (r_cand - N_BOTOES'(1))) != '0;
`endif

  // Raw levels are asynchronous to clock; two flops before anything looks at them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1 <= '0;
      r_sinc  <= '0;
    end else begin
      r_sinc1 <= botoes_raw;
      r_sinc  <= r_sinc1;
    end
  end

  assign w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_resolvido = r_cand & (~r_cand + N_BOTOES'(1));

  always_comb begin
    w_indice = '0;
    for (int i = N_BOTOES - 1; i >= 0; i--) begin
      if (r_cand[i]) w_indice = COD_W'(i);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_botoes   <= '0;
      r_codigo   <= '0;
      r_pulso    <= 1'b0;
      r_multiplo <= 1'b0;
    end else begin
      r_estado   <= w_prox_estado;
      r_cand     <= w_prox_cand;
      r_cnt      <= w_prox_cnt;
      r_botoes   <= w_prox_botoes;
      r_codigo   <= w_prox_codigo;
      r_pulso    <= w_prox_pulso;
      r_multiplo <= w_prox_multiplo;
    end
  end

  always_comb begin
    w_prox_estado   = r_estado;
    w_prox_cand     = r_cand;
    w_prox_cnt      = r_cnt;
    w_prox_botoes   = r_botoes;
    w_prox_codigo   = r_codigo;
    w_prox_pulso    = 1'b0;
    w_prox_multiplo = r_multiplo;
    case (r_estado)
      OCIOSO: begin
        if (r_sinc != '0 && habilita) begin
          w_prox_cand   = r_sinc;
          w_prox_cnt    = '0;
          w_prox_estado = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (!habilita || r_sinc == '0) begin
          w_prox_estado = OCIOSO;
        end else if (r_sinc != r_cand) begin
          w_prox_cand = r_sinc;
          w_prox_cnt  = '0;
        end else if (r_cnt == CNT_FIM) begin
`ifdef REJEITA_MULTIPLOS_EN
          if (w_multiplos) begin
            w_prox_multiplo = 1'b1;
            w_prox_cnt      = '0;
            w_prox_estado   = REJEITADO;
          end else
`endif
          begin
            w_prox_botoes = w_resolvido;
            w_prox_codigo = w_indice;
            w_prox_pulso  = 1'b1;
            w_prox_estado = PRESSIONADO;
          end
        end else begin
          w_prox_cnt = w_cnt_inc;
        end
      end
      PRESSIONADO: begin
        if (r_sinc == '0) begin
          w_prox_cnt    = '0;
          w_prox_estado = SOLTANDO;
        end
      end
      // Release must be stable too; a bounce back to pressed never re-pulses.
      SOLTANDO: begin
        if (r_sinc != '0) begin
          w_prox_estado = PRESSIONADO;
        end else if (r_cnt == CNT_FIM) begin
          w_prox_botoes = '0;
          w_prox_estado = OCIOSO;
        end else begin
          w_prox_cnt = w_cnt_inc;
        end
      end
`ifdef REJEITA_MULTIPLOS_EN
      REJEITADO: begin
        if (r_sinc != '0) begin
          w_prox_cnt = '0;
        end else if (r_cnt == CNT_FIM) begin
          w_prox_multiplo = 1'b0;
          w_prox_estado   = OCIOSO;
        end else begin
          w_prox_cnt = w_cnt_inc;
        end
      end
`endif
      default: w_prox_estado = OCIOSO;
    endcase
  end

  assign botoes        = r_botoes;
  assign jogada_pulso  = r_pulso;
  assign jogada_codigo = r_codigo;
  assign multiplo      = r_multiplo;
  assign db_estado     = r_estado;

endmodule
